// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button front end.
package btn_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      HELD_DELAY   = 3'd2,
      HELD_REPEAT  = 3'd3,
      RELEASE_WAIT = 3'd4
   } chan_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      max3 = (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: synchroniser, debounce/typematic FSM with a single shared counter,
// and registered level/press/release outputs.
module btn_chan
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES      = 2,
   parameter int DEBOUNCE_CYC     = 750000,
   parameter int REPEAT_DELAY_CYC = 22500000,
   parameter int REPEAT_RATE_CYC  = 5625000
) (
   input  logic pclk,
   input  logic rst,
   input  logic btn_in,
   input  logic repeat_en,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int CNT_W = $clog2(max3(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_RATE_CYC) + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY_CYC - 1);
   localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_s;
   chan_state_e            state_r, state_s;
   logic [CNT_W-1:0]       cnt_r, cnt_s;
   logic                   level_s, press_s, release_s;

   assign sync_s = sync_r[SYNC_STAGES-1];

   // Synchroniser shift chain for the raw pin.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
      end
   end

   // Next-state, counter and output decode.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      level_s   = btn_level;
      press_s   = 1'b0;
      release_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (sync_s) begin
               state_s = PRESS_WAIT;
               cnt_s   = CNT_ONE;
            end else begin
               cnt_s   = CNT_ZERO;
            end
         end
         PRESS_WAIT: begin
            if (!sync_s) begin
               state_s = IDLE;
               cnt_s   = CNT_ZERO;
            end else if (cnt_r >= DEB_LAST) begin
               state_s = HELD_DELAY;
               cnt_s   = CNT_ZERO;
               level_s = 1'b1;
               press_s = 1'b1;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         HELD_DELAY: begin
            if (!sync_s) begin
               state_s = RELEASE_WAIT;
               cnt_s   = CNT_ONE;
            end else if (cnt_r >= DLY_LAST) begin
               // Saturate while repeat is disabled so enabling it strobes at once.
               if (repeat_en) begin
                  state_s = HELD_REPEAT;
                  cnt_s   = CNT_ZERO;
                  press_s = 1'b1;
               end else begin
                  cnt_s   = DLY_LAST;
               end
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         HELD_REPEAT: begin
            if (!sync_s) begin
               state_s = RELEASE_WAIT;
               cnt_s   = CNT_ONE;
            end else if (!repeat_en) begin
               state_s = HELD_DELAY;
               cnt_s   = DLY_LAST;
            end else if (cnt_r >= RATE_LAST) begin
               cnt_s   = CNT_ZERO;
               press_s = 1'b1;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (sync_s) begin
               state_s = HELD_DELAY;
               cnt_s   = CNT_ZERO;
            end else if (cnt_r >= DEB_LAST) begin
               state_s   = IDLE;
               cnt_s     = CNT_ZERO;
               level_s   = 1'b0;
               release_s = 1'b1;
            end else begin
               cnt_s     = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
            level_s = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= CNT_ZERO;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         btn_level   <= level_s;
         btn_press   <= press_s;
         btn_release <= release_s;
      end
   end

endmodule

// File: rtl/btn_input_ctl.sv
// N-channel push-button front end: one independent btn_chan per button,
// wired onto the output buses.
module btn_input_ctl
   import btn_pkg::*;
#(
   parameter int N_BTN            = 4,
   parameter int SYNC_STAGES      = 2,
   parameter int DEBOUNCE_CYC     = 750000,
   parameter int REPEAT_DELAY_CYC = 22500000,
   parameter int REPEAT_RATE_CYC  = 5625000
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   input  logic [N_BTN-1:0] repeat_en,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      btn_chan #(
         .SYNC_STAGES      (SYNC_STAGES),
         .DEBOUNCE_CYC     (DEBOUNCE_CYC),
         .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
         .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
      ) u_chan (
         .pclk        (pclk),
         .rst         (rst),
         .btn_in      (btn_in[i]),
         .repeat_en   (repeat_en[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i])
      );
   end

endmodule
